// File: rtl/tune_pkg.sv
// Shared constants and types for the tune phrase loader.
// Phrase layout: freq0,dur0,...,freq3,dur3,repThreshold, MSB first.
package tune_pkg;

    localparam int NOTES      = 4;
    localparam int FIELD_W    = 32;
    localparam int REP_W      = 8;
    localparam int FRAME_BITS = NOTES * 2 * FIELD_W + REP_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        PLAYING
    } loader_state_t;

    function automatic logic [FIELD_W-1:0] freq_field(
        input logic [FRAME_BITS-1:0] frame,
        input int n
    );
        return frame[FRAME_BITS-1-2*n*FIELD_W -: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] dur_field(
        input logic [FRAME_BITS-1:0] frame,
        input int n
    );
        return frame[FRAME_BITS-1-(2*n+1)*FIELD_W -: FIELD_W];
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// Oversampled SPI receiver: synchronisers, edge detect, shadow
// shift register and saturating bit counter for one phrase frame.
module spi_frame_rx
    import tune_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    input  logic                  hold,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frameValid,
    output logic                  frameBad,
    output logic                  frameStale
);

    localparam logic [8:0] FULL = 9'(FRAME_BITS);
    localparam logic [8:0] SAT  = 9'(FRAME_BITS + 1);

    logic [2:0] sck_q;
    logic [1:0] sdi_q;
    logic [2:0] load_q;
    logic [1:0] live;
    logic       armed;
    logic       in_frame;
    logic       stale;
    logic [8:0] count;

    logic sck_rise;
    logic load_rise;
    logic load_fall;
    logic shift_en;
    logic at_full;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign load_rise = load_q[1] & ~load_q[2] & armed;
    assign load_fall = ~load_q[1] & load_q[2] & in_frame;
    assign shift_en  = sck_rise & load_q[1] & in_frame;
    assign at_full   = (count == FULL);

    assign frameValid = load_fall & at_full & ~stale;
    assign frameStale = load_fall & at_full & stale;
    assign frameBad   = load_fall & ~at_full;

    // A frame already in flight when reset releases is ignored:
    // only a load rise seen after a synced low arms the receiver.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q    <= '0;
            sdi_q    <= '0;
            load_q   <= '0;
            live     <= '0;
            armed    <= 1'b0;
            in_frame <= 1'b0;
            stale    <= 1'b0;
            count    <= '0;
            frame    <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            sdi_q  <= {sdi_q[0], sdi};
            load_q <= {load_q[1:0], load};
            live   <= {live[0], 1'b1};
            if (live[1] && !load_q[1]) begin
                armed <= 1'b1;
            end
            if (load_rise) begin
                in_frame <= 1'b1;
                count    <= '0;
                stale    <= 1'b0;
            end else if (load_fall) begin
                in_frame <= 1'b0;
            end
            if (shift_en) begin
                if (count != SAT) begin
                    count <= count + 9'd1;
                end
                if (hold) begin
                    stale <= 1'b1;
                end else begin
                    frame <= {frame[FRAME_BITS-2:0], sdi_q[1]};
                end
            end
        end
    end

endmodule

// File: rtl/tune_loader.sv
// Phrase loader for tune: receives SPI frames, queues one phrase
// and starts it only when tune is not already playing.
module tune_loader
    import tune_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        sdi,
    input  logic        load,
    input  logic        makingMusic,
    output logic [31:0] freq0,
    output logic [31:0] freq1,
    output logic [31:0] freq2,
    output logic [31:0] freq3,
    output logic [31:0] dur0,
    output logic [31:0] dur1,
    output logic [31:0] dur2,
    output logic [31:0] dur3,
    output logic [7:0]  repThreshold,
    output logic        start,
    output logic        busy,
    output logic        frameErr,
    output logic        dropped
);

    localparam int WW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

    logic [FRAME_BITS-1:0] frame;
    logic                  frame_valid;
    logic                  frame_bad;
    logic                  frame_stale;
    logic                  pending;
    loader_state_t         state;
    logic [WW-1:0]         wait_cnt;

    spi_frame_rx rx (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .load       (load),
        .hold       (pending),
        .frame      (frame),
        .frameValid (frame_valid),
        .frameBad   (frame_bad),
        .frameStale (frame_stale)
    );

    assign busy  = (state != IDLE);
    assign start = (state == START);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            wait_cnt     <= '0;
            frameErr     <= 1'b0;
            dropped      <= 1'b0;
            freq0        <= '0;
            freq1        <= '0;
            freq2        <= '0;
            freq3        <= '0;
            dur0         <= '0;
            dur1         <= '0;
            dur2         <= '0;
            dur3         <= '0;
            repThreshold <= '0;
        end else begin
            frameErr <= frame_bad;
            // Stale frames lost bits while the shadow was frozen.
            dropped  <= frame_stale | (frame_valid & pending);
            if (state == LOAD) begin
                pending <= 1'b0;
            end else if (frame_valid && !pending) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if ((pending || frame_valid) && !makingMusic) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    freq0        <= freq_field(frame, 0);
                    freq1        <= freq_field(frame, 1);
                    freq2        <= freq_field(frame, 2);
                    freq3        <= freq_field(frame, 3);
                    dur0         <= dur_field(frame, 0);
                    dur1         <= dur_field(frame, 1);
                    dur2         <= dur_field(frame, 2);
                    dur3         <= dur_field(frame, 3);
                    repThreshold <= frame[REP_W-1:0];
                    state        <= START;
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (makingMusic) begin
                        state <= PLAYING;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PLAYING: begin
                    if (!makingMusic) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tune_loader.sv
// Directed bench for tune_loader: nominal, queued, length errors,
// overflow, timeout and mid-frame reset.
module tb_tune_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        load = 1'b0;
    logic        makingMusic = 1'b0;
    logic [31:0] freq0, freq1, freq2, freq3;
    logic [31:0] dur0, dur1, dur2, dur3;
    logic [7:0]  repThreshold;
    logic        start, busy, frameErr, dropped;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    tune_loader dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .sdi          (sdi),
        .load         (load),
        .makingMusic  (makingMusic),
        .freq0        (freq0),
        .freq1        (freq1),
        .freq2        (freq2),
        .freq3        (freq3),
        .dur0         (dur0),
        .dur1         (dur1),
        .dur2         (dur2),
        .dur3         (dur3),
        .repThreshold (repThreshold),
        .start        (start),
        .busy         (busy),
        .frameErr     (frameErr),
        .dropped      (dropped)
    );

    always @(posedge clk) begin
        if (start) start_cnt++;
        if (frameErr) err_cnt++;
        if (dropped) drop_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag,
                             input logic [31:0] f0, f1, f2, f3,
                             input logic [31:0] d0, d1, d2, d3,
                             input logic [7:0] r);
        check({tag, ".freq0"}, freq0, f0);
        check({tag, ".freq1"}, freq1, f1);
        check({tag, ".freq2"}, freq2, f2);
        check({tag, ".freq3"}, freq3, f3);
        check({tag, ".dur0"}, dur0, d0);
        check({tag, ".dur1"}, dur1, d1);
        check({tag, ".dur2"}, dur2, d2);
        check({tag, ".dur3"}, dur3, d3);
        check({tag, ".rep"}, {24'd0, repThreshold}, {24'd0, r});
    endtask

    function automatic logic [271:0] mk(
        input logic [31:0] f0, f1, f2, f3,
        input logic [31:0] d0, d1, d2, d3,
        input logic [7:0] r
    );
        return {f0, d0, f1, d1, f2, d2, f3, d3, r, 8'h00};
    endfunction

    // Sends n bits MSB first; optionally pulses reset before bit rst_at.
    task automatic send_frame(input logic [271:0] v, input int n,
                              input int rst_at = -1);
        load = 1'b1;
        tick(4);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            sdi = v[271-i];
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
        load = 1'b0;
    endtask

    initial begin
        logic [271:0] fa, fb, fc, fd, fg;
        int s0, e0, d0c;
        fa = mk(3, 5, 1, 2, 20, 15, 6, 15, 2);
        fb = mk(9, 12, 4, 6, 25, 20, 7, 9, 1);
        fc = mk(7, 8, 9, 10, 11, 12, 13, 14, 3);
        fd = mk(32'hdead0001, 32'hdead0002, 32'hdead0003, 32'hdead0004,
                32'hbeef0001, 32'hbeef0002, 32'hbeef0003, 32'hbeef0004,
                8'hee);
        fg = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst.start", {31'd0, start}, 0);
        check("rst.busy", {31'd0, busy}, 0);
        check("rst.frameErr", {31'd0, frameErr}, 0);
        check("rst.dropped", {31'd0, dropped}, 0);
        check_out("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(8);

        // Nominal: start at the 4th edge after load drops
        send_frame(fa, 264);
        tick(3);
        check("nom.start_early", {31'd0, start}, 0);
        check("nom.frameErr", {31'd0, frameErr}, 0);
        tick(1);
        check("nom.start", {31'd0, start}, 1);
        check("nom.busy", {31'd0, busy}, 1);
        check_out("nom", 3, 5, 1, 2, 20, 15, 6, 15, 2);
        tick(1);
        check("nom.start_once", {31'd0, start}, 0);
        tick(2);
        makingMusic = 1'b1;
        tick(5);
        check("nom.playing_busy", {31'd0, busy}, 1);
        check("nom.start_cnt", start_cnt, 1);

        // Queued: frame arrives while playing
        send_frame(fb, 264);
        tick(6);
        check("q.start_held", start_cnt, 1);
        check("q.busy", {31'd0, busy}, 1);
        check_out("q.hold", 3, 5, 1, 2, 20, 15, 6, 15, 2);
        makingMusic = 1'b0;
        tick(2);
        check("q.start_early", {31'd0, start}, 0);
        check_out("q.pre", 3, 5, 1, 2, 20, 15, 6, 15, 2);
        tick(1);
        check("q.start", {31'd0, start}, 1);
        check_out("q.new", 9, 12, 4, 6, 25, 20, 7, 9, 1);

        // Timeout: makingMusic never rises
        tick(64);
        check("to.busy_last", {31'd0, busy}, 1);
        tick(1);
        check("to.busy_fall", {31'd0, busy}, 0);
        tick(10);
        check("to.no_retry", start_cnt, 2);

        // Length errors
        e0 = err_cnt;
        send_frame(fa, 263);
        tick(3);
        check("len263.frameErr", {31'd0, frameErr}, 1);
        tick(1);
        check("len263.pulse", {31'd0, frameErr}, 0);
        check("len263.start", {31'd0, start}, 0);
        tick(4);
        send_frame(fa, 265);
        tick(3);
        check("len265.frameErr", {31'd0, frameErr}, 1);
        tick(4);
        check("len.err_cnt", err_cnt - e0, 2);
        check("len.start_cnt", start_cnt, 2);
        check("len.busy", {31'd0, busy}, 0);
        check_out("len", 9, 12, 4, 6, 25, 20, 7, 9, 1);

        // Overflow: second valid frame while one is pending
        makingMusic = 1'b1;
        d0c = drop_cnt;
        send_frame(fc, 264);
        tick(3);
        check("ov.first_drop", {31'd0, dropped}, 0);
        tick(4);
        check("ov.pending_nostart", start_cnt, 2);
        send_frame(fd, 264);
        tick(3);
        check("ov.dropped", {31'd0, dropped}, 1);
        tick(1);
        check("ov.drop_pulse", {31'd0, dropped}, 0);
        check("ov.drop_cnt", drop_cnt - d0c, 1);
        tick(4);
        makingMusic = 1'b0;
        tick(1);
        check("ov.start_early", {31'd0, start}, 0);
        tick(1);
        check("ov.start", {31'd0, start}, 1);
        check_out("ov", 7, 8, 9, 10, 11, 12, 13, 14, 3);
        makingMusic = 1'b1;
        tick(3);
        makingMusic = 1'b0;
        tick(3);
        check("ov.idle", {31'd0, busy}, 0);

        // Reset mid-frame at bit 100
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(fg, 264, 100);
        tick(8);
        check("rmf.frameErr", err_cnt - e0, 0);
        check("rmf.start", start_cnt - s0, 0);
        check("rmf.busy", {31'd0, busy}, 0);
        check_out("rmf", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(fg, 264);
        tick(4);
        check("rmf.next_start", {31'd0, start}, 1);
        check_out("rmf.next", 1, 2, 3, 4, 5, 6, 7, 8, 9);
        tick(2);
        check("rmf.start_cnt", start_cnt - s0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
